// File: rtl/hilo_div_unit.sv
// hilo_div_unit: iterative radix-2 restoring divider producing {HI=remainder, LO=quotient}
module hilo_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   srcA,
  input  logic [WIDTH-1:0]   srcB,
  input  logic               annul,
  output logic               stall,
  output logic               result_valid,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] IDLE = 2'd0, DIV = 2'd1, DONE = 2'd2;
  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvs, abs_a, abs_b, nrem, nquo, fix_r, fix_q;
  logic [WIDTH:0]   rem_sh, diff;
  logic             neg_q, neg_r, ge;
  assign stall        = (state == IDLE && start && !annul) || state == DIV;
  assign result_valid = state == DONE && !annul;
  assign abs_a  = (is_signed && srcA[WIDTH-1]) ? -srcA : srcA;
  assign abs_b  = (is_signed && srcB[WIDTH-1]) ? -srcB : srcB;
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs};
  assign ge     = !diff[WIDTH];
  assign nrem   = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign nquo   = {quo[WIDTH-2:0], ge};
  assign fix_q  = neg_q ? -nquo : nquo;
  assign fix_r  = neg_r ? -nrem : nrem;
  // control state, restoring datapath and result capture on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else if (annul) begin
      state <= IDLE;
    end else if (state == IDLE && start) begin
      if (srcB == '0) begin
        state       <= DONE;
        result      <= {srcA, {WIDTH{1'b1}}};
        div_by_zero <= 1'b1;
      end else begin
        state <= DIV;
        cnt   <= '0;
        rem   <= '0;
        quo   <= abs_a;
        dvs   <= abs_b;
        neg_q <= is_signed && (srcA[WIDTH-1] ^ srcB[WIDTH-1]);
        neg_r <= is_signed && srcA[WIDTH-1];
      end
    end else if (state == DIV) begin
      rem <= nrem;
      quo <= nquo;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(WIDTH - 1)) begin
        state       <= DONE;
        result      <= {fix_r, fix_q};
        div_by_zero <= 1'b0;
      end
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_hilo_div_unit.sv
// tb_hilo_div_unit: directed vectors with a scoreboard queue checked by an output monitor
module tb_hilo_div_unit;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, is_signed = 1'b0, annul = 1'b0;
  logic [31:0] srcA = '0, srcB = '0;
  logic        stall, result_valid, div_by_zero;
  logic [63:0] result;
  logic [64:0] exp_q[$];
  int          total = 0, bad = 0;

  hilo_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .srcA(srcA), .srcB(srcB),
    .annul(annul), .stall(stall), .result_valid(result_valid), .result(result),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: every strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && result_valid) begin
      if (exp_q.size() == 0) chk("unexpected_strobe", {div_by_zero, result}, 65'h0);
      else chk("result", {div_by_zero, result}, exp_q.pop_front());
    end
  end

  task automatic run(input logic sg, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] er, input logic ez, input int lat);
    int n, st;
    @(negedge clk);
    start = 1'b1; is_signed = sg; srcA = a; srcB = b;
    exp_q.push_back({ez, er});
    #1 chk("stall_on_start", 65'(stall), 65'd1);
    @(posedge clk);
    #1 start = 1'b0;
    n = 0; st = 1;
    do begin
      @(negedge clk);
      n++;
      st += int'(stall);
    end while (!result_valid && n < 100);
    chk("latency", 65'(n), 65'(lat));
    chk("stall_cycles", 65'(st), 65'(lat));
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {stall, result_valid, div_by_zero, result}, 67'h0);
    rst = 1'b0;
    run(0, 32'd100, 32'd7, {32'd2, 32'd14}, 0, 33);
    run(1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 0, 33);
    run(1, 32'd7, 32'hFFFFFFFE, {32'h1, 32'hFFFFFFFD}, 0, 33);
    run(1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 0, 33);
    run(0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, 0, 33);
    run(0, 32'd5, 32'd0, {32'h5, 32'hFFFFFFFF}, 1, 1);
    run(1, 32'hFFFFFF9C, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 0, 33);
    run(0, 32'd3, 32'd10, {32'd3, 32'd0}, 0, 33);
    // annul mid-divide: no strobe, result keeps the previous value
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; srcA = 32'd50; srcB = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    #1 chk("annul_stall", 65'(stall), 65'd0);
    chk("annul_valid", 65'(result_valid), 65'd0);
    @(negedge clk);
    annul = 1'b0;
    repeat (40) @(negedge clk);
    chk("annul_hold", {div_by_zero, result}, {1'b0, 32'd3, 32'd0});
    run(0, 32'd9, 32'd3, {32'd0, 32'd3}, 0, 33);
    // annul coinciding with DONE suppresses the strobe
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; srcA = 32'd9; srcB = 32'd0;
    @(posedge clk);
    #1 start = 1'b0;
    annul = 1'b1;
    #1 chk("annul_done_valid", 65'(result_valid), 65'd0);
    @(posedge clk);
    #1 annul = 1'b0;
    chk("annul_done_idle", 65'(stall), 65'd0);
    // reset mid-divide clears outputs, then a fresh divide
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; srcA = 32'd1000; srcB = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("rst_outputs", {stall, result_valid, div_by_zero, result}, 67'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(0, 32'd1000, 32'd3, {32'd1, 32'd333}, 0, 33);
    // start held high: one strobe every 34 cycles
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; srcA = 32'd20; srcB = 32'd6;
    exp_q.push_back({1'b0, 32'd2, 32'd3});
    exp_q.push_back({1'b0, 32'd2, 32'd3});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!result_valid && n < 100);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!result_valid && n < 100);
    start = 1'b0;
    chk("b2b_period", 65'(n), 65'd34);
    repeat (3) @(negedge clk);
    chk("queue_empty", 65'(exp_q.size()), 65'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
